mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-port arbiter that shares the single memory_unit between the cpu (port 0) and a secondary master such as a UART loader or dumper (port 1).
- Each port uses a simple req/ack transaction interface.
- The arbiter serialises transactions, drives the memory address, write-data and read/write strobes, waits out the memory read latency, and returns read data with a one-cycle ack.
- Round-robin grant by default, so neither master starves.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 8, data width in bits
RD_LAT, 1, cycles from the strobe cycle to valid mem_rdata; legal range 1..7

Ports:
CLOCK  in  1  system clock, rising-edge active
RESET  in  1  synchronous, active-high reset
req0  in  1  port 0 transaction request, held until ack0
we0  in  1  port 0: 1 = write, 0 = read; sampled at grant
addr0  in  ADDR_W  port 0 address, sampled at grant
wdata0  in  DATA_W  port 0 write data, sampled at grant
ack0  out  1  port 0 one-cycle completion pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0, held until the next port 0 read ack
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_addr  out  ADDR_W  address to memory_unit
mem_wdata  out  DATA_W  write data to memory_unit
mem_rd  out  1  read strobe, one cycle
mem_wr  out  1  write strobe, one cycle
mem_rdata  in  DATA_W  read data from memory_unit
busy  out  1  high in every state except IDLE
owner  out  1  port currently or last granted

Behaviour:
- Interface: one clock domain. CLOCK is the only clock. RESET is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 (ack0/1, rdata0/1, mem_addr, mem_wdata, mem_rd, mem_wr, busy, owner); internal last_owner=1, so port 0 wins the first contest.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise pick a winner. Only one req high: that port wins. Both high: the port != last_owner wins.
  - Latch the winner's we/addr/wdata; set owner and last_owner to the winner; go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata come from the latched registers; these are the outputs at all times, not only in ISSUE.
  - Assert mem_wr if the latched we=1, else assert mem_rd.
  - Write goes to DONE; read goes to WAIT with the latency counter set to RD_LAT.
- WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, capture mem_rdata into rdata[owner] and go to DONE. WAIT lasts exactly RD_LAT cycles.
- DONE (1 cycle): ack[owner]=1; go to IDLE.
- Latency, with req seen in IDLE at cycle 0: write ack at cycle 2; read ack at cycle 2+RD_LAT. The strobe is always at cycle 1.
- Requester rules:
  - The requester holds req and its fields stable until ack.
  - It deasserts req on the edge following ack.
  - The arbiter ignores all req inputs outside IDLE.
  - Changes to addr/we/wdata after grant have no effect on the transaction in flight.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1. A waiting port is served after at most one other transaction.
- Strobes: mem_rd and mem_wr are never high together and never high outside ISSUE.
- rdata: the non-owner port's rdata is never modified. A write never modifies rdata.
- Reset mid-operation (any state): forced to IDLE next cycle with reset values.
  - The in-flight transaction is abandoned: no ack, no further strobe.
  - A write already strobed in ISSUE stays committed in memory.
- Back-to-back: the minimum gap between successive grants is one IDLE cycle after DONE.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins a contest; last_owner is unused, and port 1 is served only in an IDLE cycle where req0=0.
- Undefined: round-robin as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Reset: hold RESET 2 cycles with req0=req1=1 -> all outputs 0, busy=0, no strobes; after release, port 0 is granted first.
- Port 0 write then read: write addr0=0x05, wdata0=0xA5 -> mem_wr high at cycle 1 with mem_addr=0x05, mem_wdata=0xA5; ack0 at cycle 2. Then read 0x05 -> mem_rd at cycle 1; ack0 at cycle 3 (RD_LAT=1) with rdata0=0xA5; rdata1 unchanged.
- Contention: both ports hold req for 4 transactions each (port 0 writes 0x10..0x13, port 1 reads) -> grant order 0,1,0,1,... and never two consecutive grants to the same port.
- Latency sweep: RD_LAT=3, port 1 reads a location preloaded with 0x3C -> ack1 exactly 5 cycles after the req cycle, rdata1=0x3C.
- Mid-op reset: assert RESET during WAIT of a port 1 read -> no ack1, rdata1 keeps its old value, state IDLE; the next port 1 read completes normally.
- MEM_ARB_FIXED_PRIO_EN build: both ports hold req -> port 0 granted on every transaction until req0 drops; port 1 is then granted in the next IDLE cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter sharing one memory_unit. Round-robin, or fixed port-0 priority under MEM_ARB_FIXED_PRIO_EN.
// Latency from grant (req seen in IDLE): strobe +1, write ack +2, read ack +2+RD_LAT; one IDLE cycle between grants.
// Backpressure: a requester holds req until its ack; req inputs are ignored outside IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("mem_bus_arbiter: RD_LAT must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        cnt;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic              last_owner;
`endif

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    // On a tie the port that did not win last time goes next.
    win = (req0 & req1) ? ~last_owner : req1;
`endif
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      cnt       <= 3'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_owner <= 1'b1;
`endif
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner     <= win;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner <= win;
`endif
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            // Strobes are registered so they are high exactly while in ISSUE.
            mem_wr    <= sel_we;
            mem_rd    <= ~sel_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            ack0  <= ~owner;
            ack1  <= owner;
            state <= DONE;
          end else begin
            cnt   <= 3'(RD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            if (owner) rdata1 <= mem_rdata;
            else       rdata0 <= mem_rdata;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter against a transaction-level model and a latency-accurate memory.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 3;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd, mem_wr, busy, owner;

  always #5 CLOCK = ~CLOCK;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] init_val(logic [7:0] a);
    return 8'(a * 37 + 11);
  endfunction

  // memory_unit stand-in: read data appears RD_LAT cycles after the strobe cycle, junk otherwise.
  logic [7:0] mem [256];
  logic [7:0] rpipe [RD_LAT];
  logic       mem_ready = 1'b0;
  always @(posedge CLOCK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_ready <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= mem_rd ? mem[mem_addr] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one transaction in flight, described by its grant cycle and completion cycle.
  logic [7:0] mmem [256];
  bit         act;
  int         t0, done_at;
  bit         tw, tport, last_own;
  logic [7:0] pend;
  logic [7:0] e_addr, e_wdata;
  logic [7:0] e_rdata [2];
  bit         e_owner;
  bit         served [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    act        = 1'b0;
    last_own   = 1'b1;
    e_addr     = 8'h00;
    e_wdata    = 8'h00;
    e_rdata[0] = 8'h00;
    e_rdata[1] = 8'h00;
    e_owner    = 1'b0;
  endfunction

  // Evaluated with the inputs of the current cycle, i.e. what the DUT samples at the coming edge.
  function automatic void model_grant();
    bit w;
    if (RESET) begin
      model_reset();
      return;
    end
    if (act) begin
      if (cyc == done_at) act = 1'b0;
      return;
    end
    if (!req0 && !req1) return;
`ifdef MEM_ARB_FIXED_PRIO_EN
    w = !req0;
`else
    w = (req0 && req1) ? !last_own : req1;
`endif
    act      = 1'b1;
    t0       = cyc;
    tport    = w;
    tw       = w ? we1 : we0;
    e_addr   = w ? addr1 : addr0;
    e_wdata  = w ? wdata1 : wdata0;
    done_at  = cyc + (tw ? 2 : 2 + RD_LAT);
    last_own = w;
    e_owner  = w;
    if (tw) mmem[e_addr] = e_wdata;
    else    pend = mmem[e_addr];
  endfunction

  task automatic check_cycle();
    bit ea0, ea1, erd, ewr;
    ea0 = 1'b0; ea1 = 1'b0; erd = 1'b0; ewr = 1'b0;
    served[0] = 1'b0;
    served[1] = 1'b0;
    if (act) begin
      if (cyc == done_at) begin
        if (!tw) e_rdata[tport] = pend;
        if (tport) ea1 = 1'b1;
        else       ea0 = 1'b1;
        served[tport] = 1'b1;
      end
      erd = (cyc == t0 + 1) && !tw;
      ewr = (cyc == t0 + 1) && tw;
    end
    check("ack0",      32'(ack0),      32'(ea0));
    check("ack1",      32'(ack1),      32'(ea1));
    check("mem_rd",    32'(mem_rd),    32'(erd));
    check("mem_wr",    32'(mem_wr),    32'(ewr));
    check("mem_addr",  32'(mem_addr),  32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("rdata0",    32'(rdata0),    32'(e_rdata[0]));
    check("rdata1",    32'(rdata1),    32'(e_rdata[1]));
    check("busy",      32'(busy),      32'(act));
    check("owner",     32'(owner),     32'(e_owner));
  endtask

  task automatic step();
    model_grant();
    @(posedge CLOCK);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic set_port(int p, bit r, bit w, logic [7:0] a, logic [7:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Holds the request until the ack cycle; the caller drives the next inputs.
  task automatic do_txn(int p, bit w, logic [7:0] a, logic [7:0] d);
    set_port(p, 1'b1, w, a, d);
    for (int i = 0; i < 20; i++) begin
      step();
      if (served[p]) break;
    end
  endtask

  // mode 1: port 0 writes 0x10.., port 1 reads 0x10..0x13; otherwise fully random traffic.
  task automatic run_mix(int n0, int n1, int pct, int maxcyc, int mode);
    int left [2];
    int idx  [2];
    bit r;
    left[0] = n0; left[1] = n1;
    idx[0]  = 0;  idx[1]  = 0;
    for (int c = 0; c < maxcyc; c++) begin
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? req0 : req1;
        if (served[p] || !r) begin
          if (left[p] > 0 && $urandom_range(99) < pct) begin
            left[p]--;
            if (mode == 1)
              set_port(p, 1'b1, p == 0,
                       (p == 0) ? 8'(8'h10 + idx[p]) : 8'(8'h10 + $urandom_range(3)),
                       8'($urandom));
            else
              set_port(p, 1'b1, 1'($urandom), 8'($urandom_range(15)), 8'($urandom));
            idx[p]++;
          end else begin
            set_port(p, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
          end
        end
      end
      if (left[0] == 0 && left[1] == 0 && !req0 && !req1 && !act) break;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
    model_reset();
    served[0] = 1'b0;
    served[1] = 1'b0;

    // Reset held two cycles with both ports requesting.
    RESET = 1'b1;
    set_port(0, 1'b1, 1'b1, 8'h20, 8'h11);
    set_port(1, 1'b1, 1'b1, 8'h21, 8'h22);
    step();
    step();
    RESET = 1'b0;
    step();
    check("first_grant_addr", 32'(mem_addr), 32'h20);
    check("first_grant_wr", 32'(mem_wr), 32'(1));
    for (int i = 0; i < 30; i++) begin
      if (served[0]) req0 = 1'b0;
      if (served[1]) req1 = 1'b0;
      if (!req0 && !req1 && !act) break;
      step();
    end

    // Port 0 write then read back.
    do_txn(0, 1'b1, 8'h05, 8'hA5);
    do_txn(0, 1'b0, 8'h05, 8'h00);
    check("p0_read_a5", 32'(rdata0), 32'hA5);
    check("p1_rdata_untouched", 32'(rdata1), 32'h00);
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Reset in the middle of a port 1 read wait.
    set_port(1, 1'b1, 1'b0, 8'h07, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      if (act) break;
    end
    step();
    RESET = 1'b1;
    set_port(1, 1'b0, 1'b0, 8'h07, 8'h00);
    step();
    RESET = 1'b0;
    check("midrst_no_ack1", 32'(ack1), 32'(0));
    check("midrst_idle", 32'(busy), 32'(0));
    check("midrst_rdata1", 32'(rdata1), 32'h00);
    step();
    do_txn(1, 1'b0, 8'h07, 8'h00);
    check("p1_read_after_rst", 32'(rdata1), 32'(mmem[8'h07]));

    // Read through the full RD_LAT wait.
    do_txn(0, 1'b1, 8'h40, 8'h3C);
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1, 1'b0, 8'h40, 8'h00);
    check("lat_read_3c", 32'(rdata1), 32'h3C);
    set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Continuous contention, then random traffic.
    run_mix(4, 4, 100, 300, 1);
    run_mix(40, 40, 60, 3000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
